// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared constants, opcode and FSM state types for the vector execution unit
package vec_pkg;

    localparam int LANES     = 8;
    localparam int LANE_W    = 32;
    localparam int REG_WIDTH = LANES * LANE_W;

    typedef enum logic [2:0] {
        OP_ADD    = 3'd0,
        OP_SUB    = 3'd1,
        OP_MUL    = 3'd2,
        OP_AND    = 3'd3,
        OP_OR     = 3'd4,
        OP_XOR    = 3'd5,
        OP_REDSUM = 3'd6,
        OP_RSVD   = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_RED  = 2'd2
    } state_t;

endpackage

// File: rtl/lane_alu.sv
// rtl/lane_alu.sv - combinational single-lane ALU; arithmetic wraps at the lane width
module lane_alu #(
    parameter int LANE_W = vec_pkg::LANE_W
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  vec_pkg::opcode_t  op,
    output logic [LANE_W-1:0] y
);
    import vec_pkg::*;

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_MUL:  y = a * b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/vec_exec_unit.sv
// rtl/vec_exec_unit.sv - SIMD execute stage: lane ALUs, staged reduction tree and issue/write-back FSM
module vec_exec_unit #(
    parameter int LANES    = vec_pkg::LANES,
    parameter int LANE_W   = vec_pkg::LANE_W,
    parameter int NUM_REGS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              in_op,
    input  logic [4:0]              in_rd,
    input  logic [LANES*LANE_W-1:0] in_a,
    input  logic [LANES*LANE_W-1:0] in_b,
    output logic                    wb_we,
    output logic [4:0]              wb_addr,
    output logic [LANES*LANE_W-1:0] wb_data,
    output logic                    err
);
    import vec_pkg::*;

    localparam int         VEC_W    = LANES * LANE_W;
    localparam logic [1:0] RED_LAST = 2'($clog2(LANES) - 1);

    // One adder-tree level: pairs collapse into the low half, upper lanes clear.
    function automatic logic [VEC_W-1:0] reduce_level(input logic [VEC_W-1:0] v);
        logic [VEC_W-1:0] r;
        r = '0;
        for (int i = 0; i < LANES / 2; i++) begin
            r[i*LANE_W +: LANE_W] = v[2*i*LANE_W +: LANE_W] + v[(2*i+1)*LANE_W +: LANE_W];
        end
        return r;
    endfunction

    state_t           state, state_next;
    logic [1:0]       red_cnt;
    logic [VEC_W-1:0] a_q, b_q, tree, tree_next;
    logic [4:0]       rd_q, fin_rd;
    logic [VEC_W-1:0] alu_a, alu_b, alu_y, fin_data;
    opcode_t          alu_op;
    logic             issue, fin, fin_rd_ok, err_now;

    // MUL is evaluated from captured operands in its second cycle.
    assign alu_a     = (state == ST_MUL) ? a_q : in_a;
    assign alu_b     = (state == ST_MUL) ? b_q : in_b;
    assign alu_op    = (state == ST_MUL) ? OP_MUL : opcode_t'(in_op);
    assign tree_next = reduce_level(tree);
    assign fin_rd_ok = 32'(fin_rd) < NUM_REGS;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lane_alu #(.LANE_W(LANE_W)) u_lane_alu (
            .a  (alu_a[g*LANE_W +: LANE_W]),
            .b  (alu_b[g*LANE_W +: LANE_W]),
            .op (alu_op),
            .y  (alu_y[g*LANE_W +: LANE_W])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        issue      = 1'b0;
        fin        = 1'b0;
        fin_rd     = rd_q;
        fin_data   = alu_y;
        err_now    = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = !rst;
                issue    = in_valid && !rst;
                if (issue) begin
                    case (opcode_t'(in_op))
                        OP_MUL:    state_next = ST_MUL;
                        OP_REDSUM: state_next = ST_RED;
                        OP_RSVD:   err_now    = 1'b1;
                        default: begin
                            fin    = 1'b1;
                            fin_rd = in_rd;
                        end
                    endcase
                end
            end
            ST_MUL: begin
                fin        = 1'b1;
                state_next = ST_IDLE;
            end
            ST_RED: begin
                fin_data = tree_next;
                if (red_cnt == RED_LAST) begin
                    fin        = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_we   <= 1'b0;
            err     <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
            red_cnt <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            tree    <= '0;
        end else begin
            wb_we <= fin && fin_rd_ok;
            err   <= err_now || (fin && !fin_rd_ok);
            if (fin && fin_rd_ok) begin
                wb_addr <= fin_rd;
                wb_data <= fin_data;
            end
            if (issue) begin
                a_q     <= in_a;
                b_q     <= in_b;
                rd_q    <= in_rd;
                tree    <= in_a;
                red_cnt <= '0;
            end else if (state == ST_RED) begin
                tree    <= tree_next;
                red_cnt <= red_cnt + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_vec_exec_unit.sv
// tb/tb_vec_exec_unit.sv - self-checking bench for vec_exec_unit against a lane-level reference model
module tb_vec_exec_unit;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   in_op = '0;
    logic [4:0]   in_rd = '0;
    logic [255:0] in_a = '0;
    logic [255:0] in_b = '0;
    logic         wb_we;
    logic [4:0]   wb_addr;
    logic [255:0] wb_data;
    logic         err;

    int tests = 0;
    int fails = 0;

    vec_exec_unit dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_rd    (in_rd),
        .in_a     (in_a),
        .in_b     (in_b),
        .wb_we    (wb_we),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [255:0] model_result(input int op, input logic [255:0] a, input logic [255:0] b);
        logic [255:0] r;
        logic [31:0]  x, y, s;
        r = '0;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            x = a[i*32 +: 32];
            y = b[i*32 +: 32];
            case (op)
                0: r[i*32 +: 32] = x + y;
                1: r[i*32 +: 32] = x - y;
                2: r[i*32 +: 32] = x * y;
                6: s = s + x;
                default: ;
            endcase
        end
        case (op)
            3: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            6: r[31:0] = s;
            default: ;
        endcase
        return r;
    endfunction

    function automatic int model_latency(input int op);
        if (op == 2) return 2;
        if (op == 6) return 4;
        return 1;
    endfunction

    function automatic logic [255:0] splat(input logic [31:0] v);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = v;
        return r;
    endfunction

    // Issues one op when the unit is ready and checks write-back/err timing, data and hold.
    task automatic do_op(input string tag, input int op, input int rd, input logic [255:0] a, input logic [255:0] b);
        int lat, wb_cnt, err_cnt, wb_cyc, err_cyc, waited;
        logic [255:0] expv, got_data;
        logic [4:0]   got_addr;
        bit rd_ok;
        lat = model_latency(op);
        expv = model_result(op, a, b);
        rd_ok = rd < 8;
        wb_cnt = 0; err_cnt = 0; wb_cyc = 0; err_cyc = 0; waited = 0;
        got_data = '0; got_addr = '0;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_ready"}, 256'(in_ready), 256'(1));
        in_valid = 1'b1;
        in_op = 3'(op);
        in_rd = 5'(rd);
        in_a = a;
        in_b = b;
        for (int k = 1; k <= lat + 2; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_a = ~a;
            in_b = ~b;
            if (k < lat) chk($sformatf("%s_busy%0d", tag, k), 256'(in_ready), 256'(0));
            if (k == lat + 1 && op != 7 && rd_ok) chk({tag, "_hold"}, wb_data, expv);
            if (wb_we) begin
                wb_cnt++;
                wb_cyc = k;
                got_addr = wb_addr;
                got_data = wb_data;
            end
            if (err) begin
                err_cnt++;
                err_cyc = k;
            end
        end
        if (op == 7 || !rd_ok) begin
            chk({tag, "_wb_cnt"}, 256'(wb_cnt), 256'(0));
            chk({tag, "_err_cnt"}, 256'(err_cnt), 256'(1));
            chk({tag, "_err_cyc"}, 256'(err_cyc), 256'(op == 7 ? 1 : lat));
        end else begin
            chk({tag, "_wb_cnt"}, 256'(wb_cnt), 256'(1));
            chk({tag, "_wb_cyc"}, 256'(wb_cyc), 256'(lat));
            chk({tag, "_addr"}, 256'(got_addr), 256'(rd));
            chk({tag, "_data"}, got_data, expv);
            chk({tag, "_err_cnt"}, 256'(err_cnt), 256'(0));
        end
    endtask

    initial begin
        logic [255:0] va, vb;
        int wb_seen;

        // Reset state
        #2;
        chk("rst_ready", 256'(in_ready), 256'(0));
        chk("rst_we", 256'(wb_we), 256'(0));
        chk("rst_err", 256'(err), 256'(0));
        chk("rst_addr", 256'(wb_addr), 256'(0));
        chk("rst_data", wb_data, 256'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_ready", 256'(in_ready), 256'(1));

        // Directed cases
        do_op("add_wrap", 0, 3, splat(32'hFFFF_FFFF), splat(32'h1));
        do_op("mul_wrap", 2, 5, splat(32'h0001_0000), splat(32'h0001_0000));
        do_op("mul_small", 2, 4, splat(32'd7), splat(32'd6));
        for (int i = 0; i < 8; i++) va[i*32 +: 32] = 32'(i + 1);
        do_op("redsum", 6, 6, va, splat(32'hDEAD_BEEF));
        do_op("illegal_op", 7, 2, splat(32'd1), splat(32'd2));
        do_op("bad_rd", 0, 9, splat(32'd1), splat(32'd2));
        do_op("bad_rd_mul", 2, 8, splat(32'd3), splat(32'd3));
        do_op("and", 3, 0, {8{32'hF0F0_1234}}, {8{32'h0FF0_FF00}});
        do_op("or", 4, 7, {8{32'hA000_0001}}, {8{32'h0500_0010}});

        // Back-to-back XOR then SUB
        va = {8{32'h1234_5678}};
        vb = {8{32'h0F0F_0F0F}};
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'd5; in_rd = 5'd1; in_a = va; in_b = vb;
        @(negedge clk);
        chk("b2b_we1", 256'(wb_we), 256'(1));
        chk("b2b_addr1", 256'(wb_addr), 256'(1));
        chk("b2b_data1", wb_data, model_result(5, va, vb));
        chk("b2b_ready", 256'(in_ready), 256'(1));
        in_op = 3'd1; in_rd = 5'd2; in_a = vb; in_b = va;
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_we2", 256'(wb_we), 256'(1));
        chk("b2b_addr2", 256'(wb_addr), 256'(2));
        chk("b2b_data2", wb_data, model_result(1, vb, va));
        @(negedge clk);
        chk("b2b_we_off", 256'(wb_we), 256'(0));

        // Reset in the middle of a reduction
        for (int i = 0; i < 8; i++) va[i*32 +: 32] = 32'(10 * i + 3);
        in_valid = 1'b1; in_op = 3'd6; in_rd = 5'd6; in_a = va;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midred_rst_ready", 256'(in_ready), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midred_rel_ready", 256'(in_ready), 256'(1));
        wb_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (wb_we) wb_seen++;
        end
        chk("midred_no_wb", 256'(wb_seen), 256'(0));

        // Randomized ops against the reference model
        for (int n = 0; n < 40; n++) begin
            int op, rd;
            op = int'($urandom_range(7, 0));
            rd = int'($urandom_range(9, 0));
            for (int i = 0; i < 8; i++) begin
                va[i*32 +: 32] = $urandom;
                vb[i*32 +: 32] = $urandom;
            end
            do_op($sformatf("rnd%0d_op%0d", n, op), op, rd, va, vb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
